adc_spi_capture: RTL and testbench

ADC_SPI_CAPTURE -- requirements
Module: adc_spi_capture

---
 rtl/adc_spi_capture_if.sv | 16 +
 rtl/adc_spi_capture.sv | 108 ++++++++++
 tb/tb_adc_spi_capture.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_capture_if.sv
// Pin bundle between the ADC capture engine and its surroundings.
// master = capture engine side, slave = ADC/host side.
interface adc_spi_capture_if #(
    parameter int DATA_W = 12
);
    logic              En;
    logic              SDataIn;
    logic              SClk;
    logic              CsN;
    logic [DATA_W-1:0] Sample;
    logic              SampleValid;
    logic              Busy;

    modport master (input En, SDataIn, output SClk, CsN, Sample, SampleValid, Busy);
    modport slave  (output En, SDataIn, input SClk, CsN, Sample, SampleValid, Busy);
endinterface

// File: rtl/adc_spi_capture.sv
// Periodic SPI ADC reader: a sample timer launches one CsN frame, shifts in
// FRAME_BITS bits MSB first on rising SClk, and publishes the low DATA_W bits.
module adc_spi_capture #(
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int HALF_DIV   = 1,
    parameter int SAMPLE_DIV = 100
) (
    input  logic              ClkIn,
    input  logic              RstN,
    adc_spi_capture_if.master bus
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int PW = $clog2(2 * FRAME_BITS);
    localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HALF_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(2 * FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0]     sample_q, sample_d;
    logic                  sclk_q, sclk_d, csn_q, csn_d;
    logic                  valid_q, valid_d, busy_q, busy_d;
    logic                  tick, half_end;

    assign tick     = bus.En && (timer_q == T_LAST);
    assign half_end = (hcnt_q == H_LAST);
    assign timer_d  = (bus.En && !tick) ? timer_q + 1'b1 : '0;

    always_ff @(posedge ClkIn or negedge RstN) begin
        if (!RstN) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            hcnt_q   <= '0;
            phase_q  <= '0;
            sreg_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            hcnt_q   <= hcnt_d;
            phase_q  <= phase_d;
            sreg_q   <= sreg_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            csn_q    <= csn_d;
            sclk_q   <= sclk_d;
        end
    end

    // Even phases are SClk-low; the end of an even phase is the rising SClk edge.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        sreg_d  = sreg_q;
        case (state_q)
            IDLE: if (tick) begin
                state_d = LEAD;
                hcnt_d  = '0;
            end
            LEAD: if (half_end) begin
                state_d = SHIFT;
                hcnt_d  = '0;
                phase_d = '0;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            SHIFT: if (half_end) begin
                hcnt_d = '0;
                if (!phase_q[0])
                    sreg_d = (sreg_q << 1) | {{(FRAME_BITS-1){1'b0}}, bus.SDataIn};
                if (phase_q == P_LAST) state_d = DONE;
                else                   phase_d = phase_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the pins come straight off flops.
    always_comb begin
        csn_d    = !(state_d == LEAD || state_d == SHIFT);
        sclk_d   = !(state_d == SHIFT && !phase_d[0]);
        busy_d   = (state_d != IDLE);
        valid_d  = (state_d == DONE);
        sample_d = valid_d ? sreg_q[DATA_W-1:0] : sample_q;
    end

    assign bus.SClk        = sclk_q;
    assign bus.CsN         = csn_q;
    assign bus.Sample      = sample_q;
    assign bus.SampleValid = valid_q;
    assign bus.Busy        = busy_q;
endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: a default-parameter instance and a HALF_DIV=3
// instance, each fed by a behavioural ADC that shifts a word out on falling SClk.
module tb_adc_spi_capture;
  localparam int DW  = 12;
  localparam int FB  = 16;
  localparam int SD0 = 100;
  localparam int HD1 = 3;
  localparam int SD1 = 120;

  logic ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  logic rstn [2];
  logic en   [2];
  logic sdi  [2];
  logic sclk [2];
  logic csn  [2];
  logic svd  [2];
  logic busy [2];
  logic [DW-1:0] smp [2];

  adc_spi_capture_if #(.DATA_W(DW)) bus0 ();
  adc_spi_capture_if #(.DATA_W(DW)) bus1 ();

  adc_spi_capture #(.DATA_W(DW), .FRAME_BITS(FB), .HALF_DIV(1), .SAMPLE_DIV(SD0)) dut0 (
    .ClkIn(ClkIn), .RstN(rstn[0]), .bus(bus0));
  adc_spi_capture #(.DATA_W(DW), .FRAME_BITS(FB), .HALF_DIV(HD1), .SAMPLE_DIV(SD1)) dut1 (
    .ClkIn(ClkIn), .RstN(rstn[1]), .bus(bus1));

  assign bus0.En = en[0];  assign bus0.SDataIn = sdi[0];
  assign bus1.En = en[1];  assign bus1.SDataIn = sdi[1];
  assign sclk[0] = bus0.SClk;  assign csn[0] = bus0.CsN;  assign svd[0] = bus0.SampleValid;
  assign busy[0] = bus0.Busy;  assign smp[0] = bus0.Sample;
  assign sclk[1] = bus1.SClk;  assign csn[1] = bus1.CsN;  assign svd[1] = bus1.SampleValid;
  assign busy[1] = bus1.Busy;  assign smp[1] = bus1.Sample;

  // ADC word source and frame observations, shared with the main sequence
  logic          use_fixed;
  logic [FB-1:0] fixed_word;
  int cyc;
  int cs_falls [2], run [2], last_run [2], rises [2], last_rises [2];
  int vcnt [2], last_t [2], gap [2], dbl [2], bitidx [2], srun [2];
  int lo_min [2], lo_max [2], hi_min [2], hi_max [2];
  logic hi_from_rise [2], sv_ok [2], prev_csn [2], prev_sclk [2], prev_sv [2];
  logic [FB-1:0] word [2];
  logic [DW-1:0] exp_pend [2], last_smp [2], last_exp [2];

  // Behavioural ADC + frame monitor, evaluated on the falling ClkIn edge
  initial begin
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      sdi[i] = 1'b0; cs_falls[i] = 0; run[i] = 0; last_run[i] = 0; rises[i] = 0;
      last_rises[i] = 0; vcnt[i] = 0; last_t[i] = 0; gap[i] = 0; dbl[i] = 0;
      bitidx[i] = 0; srun[i] = 0; lo_min[i] = 0; lo_max[i] = 0; hi_min[i] = 0;
      hi_max[i] = 0; hi_from_rise[i] = 1'b0; sv_ok[i] = 1'b0; prev_csn[i] = 1'b1;
      prev_sclk[i] = 1'b1; prev_sv[i] = 1'b0; word[i] = '0; exp_pend[i] = '0;
      last_smp[i] = '0; last_exp[i] = '0;
    end
    forever begin
      @(negedge ClkIn);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (prev_csn[i] && !csn[i]) begin
          cs_falls[i]++;
          word[i] = use_fixed ? fixed_word : FB'($urandom);
          exp_pend[i] = word[i][DW-1:0];
          bitidx[i] = FB - 1; run[i] = 0; rises[i] = 0;
          lo_min[i] = 1000; lo_max[i] = 0; hi_min[i] = 1000; hi_max[i] = 0;
        end
        if (!csn[i]) run[i]++;
        if (!prev_csn[i] && csn[i]) begin
          last_run[i] = run[i];
          last_rises[i] = rises[i];
        end
        if (sclk[i] != prev_sclk[i]) begin
          if (sclk[i] && !csn[i]) begin
            rises[i]++;
            if (srun[i] < lo_min[i]) lo_min[i] = srun[i];
            if (srun[i] > lo_max[i]) lo_max[i] = srun[i];
          end
          if (!sclk[i] && !csn[i]) begin
            if (hi_from_rise[i]) begin
              if (srun[i] < hi_min[i]) hi_min[i] = srun[i];
              if (srun[i] > hi_max[i]) hi_max[i] = srun[i];
            end
            if (bitidx[i] >= 0) begin
              sdi[i] = word[i][bitidx[i]];
              bitidx[i]--;
            end
          end
          hi_from_rise[i] = sclk[i] && !csn[i];
          srun[i] = 1;
        end else begin
          srun[i]++;
        end
        if (svd[i]) begin
          if (prev_sv[i]) dbl[i]++;
          vcnt[i]++;
          gap[i] = cyc - last_t[i];
          last_t[i] = cyc;
          last_smp[i] = smp[i];
          last_exp[i] = exp_pend[i];
          sv_ok[i] = csn[i] && !prev_csn[i];
        end
        prev_csn[i] = csn[i]; prev_sclk[i] = sclk[i]; prev_sv[i] = svd[i];
      end
    end
  end

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge ClkIn); #1; end
  endtask

  task automatic wait_valid(input int i, input int target, input int budget);
    int k = 0;
    while (vcnt[i] < target && k < budget) begin @(negedge ClkIn); #1; k++; end
    chk("valid_arrived", 32'(vcnt[i] >= target), 1);
  endtask

  task automatic wait_csfall(input int i, input int target, input int budget);
    int k = 0;
    while (cs_falls[i] < target && k < budget) begin @(negedge ClkIn); #1; k++; end
    chk("csn_fell", 32'(cs_falls[i] >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, vc, nf;
    n_vec = 0; n_err = 0;
    use_fixed = 1'b1; fixed_word = 16'h0ABC;
    rstn[0] = 1'b1; rstn[1] = 1'b1; en[0] = 1'b0; en[1] = 1'b0;
    #1;
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    step(3);
    chk("rst_csn",   csn[0], 1);
    chk("rst_sclk",  sclk[0], 1);
    chk("rst_busy",  busy[0], 0);
    chk("rst_valid", svd[0], 0);
    chk("rst_sample", smp[0], 0);
    chk("rst_csn1",  csn[1], 1);
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // Timer held while disabled: no frame may start
    step(150);
    chk("en_low_no_frame", cs_falls[0], 0);

    // First frame: 0x0ABC
    en[0] = 1'b1; t0 = cyc;
    wait_valid(0, 1, 300);
    chk("f1_latency", last_t[0] - t0, SD0 + 33);
    chk("f1_sample",  last_smp[0], 12'hABC);
    chk("f1_csn_low", last_run[0], 33);
    chk("f1_rises",   last_rises[0], FB);
    chk("f1_valid_at_csn_rise", sv_ok[0], 1);
    step(1);
    chk("f1_pulse_one_cycle", svd[0], 0);
    chk("f1_busy_idle", busy[0], 0);

    // Upper frame bits are dropped
    fixed_word = 16'hFABC;
    wait_valid(0, 2, 200);
    chk("f2_sample", last_smp[0], 12'hABC);
    chk("f2_gap", gap[0], SD0);

    // Random words, steady cadence
    use_fixed = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      wait_valid(0, k, 200);
      chk("rnd_sample", last_smp[0], last_exp[0]);
      chk("rnd_gap", gap[0], SD0);
    end
    chk("ten_frames_time", last_t[0] - t0, SD0 + 33 + 9 * SD0);
    chk("no_double_valid", dbl[0], 0);

    // En dropped 5 cycles into SHIFT: frame completes, nothing after
    wait_csfall(0, cs_falls[0] + 1, 200);
    step(6);
    en[0] = 1'b0;
    vc = vcnt[0];
    wait_valid(0, vc + 1, 100);
    chk("endrop_sample", last_smp[0], last_exp[0]);
    chk("endrop_csn_low", last_run[0], 33);
    nf = cs_falls[0];
    step(300);
    chk("endrop_no_new_frame", cs_falls[0], nf);
    chk("endrop_no_new_valid", vcnt[0], vc + 1);

    // Reset 10 cycles into SHIFT: immediate idle pins, no valid
    en[0] = 1'b1;
    vc = vcnt[0];
    wait_csfall(0, cs_falls[0] + 1, 200);
    step(11);
    rstn[0] = 1'b0;
    #1;
    chk("arst_csn",  csn[0], 1);
    chk("arst_sclk", sclk[0], 1);
    chk("arst_busy", busy[0], 0);
    chk("arst_valid", svd[0], 0);
    chk("arst_sample", smp[0], 0);
    step(5);
    chk("arst_no_valid", vcnt[0], vc);
    rstn[0] = 1'b1; t0 = cyc;
    step(50);
    chk("arst_sample_held", smp[0], 0);
    wait_valid(0, vc + 1, 300);
    chk("arst_first_latency", last_t[0] - t0, SD0 + 33);
    chk("arst_first_sample", last_smp[0], last_exp[0]);
    en[0] = 1'b0;

    // HALF_DIV=3 instance
    en[1] = 1'b1; t0 = cyc;
    wait_valid(1, 1, 400);
    chk("hd3_latency", last_t[1] - t0, SD1 + HD1 + 2 * FB * HD1);
    chk("hd3_sample",  last_smp[1], last_exp[1]);
    chk("hd3_csn_low", last_run[1], HD1 + 2 * FB * HD1);
    chk("hd3_rises",   last_rises[1], FB);
    chk("hd3_lo_min",  lo_min[1], HD1);
    chk("hd3_lo_max",  lo_max[1], HD1);
    chk("hd3_hi_min",  hi_min[1], HD1);
    chk("hd3_hi_max",  hi_max[1], HD1);
    wait_valid(1, 2, 300);
    chk("hd3_sample2", last_smp[1], last_exp[1]);
    chk("hd3_gap", gap[1], SD1);
    chk("hd3_no_double_valid", dbl[1], 0);
    en[1] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
